// File: rtl/decodificador_pkg.sv
// Shared widths, state encoding and one-hot helper
// for the sequential 3-to-8 decoder.
package decodificador_pkg;

  localparam int ANCHO_CODIGO = 3;
  localparam int ANCHO_SALIDA = 8;

  typedef enum logic {
    REPOSO = 1'b0,
    ACTIVO = 1'b1
  } estado_t;

  function automatic logic [ANCHO_SALIDA-1:0] one_hot(
    input logic [ANCHO_CODIGO-1:0] c
  );
    one_hot = ANCHO_SALIDA'(1) << c;
  endfunction

endpackage

// File: rtl/fifo_sincrona.sv
// Synchronous first-word-fall-through FIFO;
// push/pop are ignored when full/empty respectively.
module fifo_sincrona #(
  parameter int ANCHO       = 3,
  parameter int PROFUNDIDAD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ANCHO-1:0] dato,
  input  logic             pop,
  output logic [ANCHO-1:0] cabeza,
  output logic             lleno,
  output logic             vacio
);

  localparam int AP = $clog2(PROFUNDIDAD);

  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  logic [AP-1:0]    wr;
  logic [AP-1:0]    rd;
  logic [AP:0]      cuenta;
  logic             hace_push;
  logic             hace_pop;

  assign lleno     = cuenta == (AP+1)'(PROFUNDIDAD);
  assign vacio     = cuenta == '0;
  assign hace_push = push && !lleno;
  assign hace_pop  = pop && !vacio;
  assign cabeza    = mem[rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr     <= '0;
      rd     <= '0;
      cuenta <= '0;
    end else begin
      if (hace_push) wr <= wr + AP'(1);
      if (hace_pop)  rd <= rd + AP'(1);
      unique case ({hace_push, hace_pop})
        2'b10:   cuenta <= cuenta + (AP+1)'(1);
        2'b01:   cuenta <= cuenta - (AP+1)'(1);
        default: cuenta <= cuenta;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (hace_push) mem[wr] <= dato;
  end

endmodule

// File: rtl/decodificador_3a8_sec.sv
// Sequential 3-to-8 decoder: queued codes replayed as
// registered one-hot strobes held DURACION enabled cycles.
module decodificador_3a8_sec
  import decodificador_pkg::*;
#(
  parameter int DURACION    = 4,
  parameter int PROFUNDIDAD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ANCHO_CODIGO-1:0] e,
  input  logic                    valido,
  output logic                    listo,
  output logic [ANCHO_SALIDA-1:0] s,
  output logic                    ocupado
);

  localparam int CW = (DURACION > 1) ? $clog2(DURACION) : 1;
  localparam logic [CW-1:0] CARGA = CW'(DURACION - 1);

  estado_t                 estado;
  logic [CW-1:0]           cuenta;
  logic [ANCHO_CODIGO-1:0] codigo;
  logic [ANCHO_CODIGO-1:0] cabeza;
  logic                    lleno;
  logic                    vacio;
  logic                    push;
  logic                    pop;

  assign listo   = !lleno && !rst;
  assign push    = valido && listo;
  assign ocupado = (estado == ACTIVO) || !vacio;

  // Pop only when idle or the current code has used its last cycle.
  assign pop = en && !vacio &&
               ((estado == REPOSO) || (cuenta == '0));

  fifo_sincrona #(
    .ANCHO      (ANCHO_CODIGO),
    .PROFUNDIDAD(PROFUNDIDAD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .dato  (e),
    .pop   (pop),
    .cabeza(cabeza),
    .lleno (lleno),
    .vacio (vacio)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= REPOSO;
      cuenta <= '0;
      codigo <= '0;
      s      <= '0;
    end else if (!en) begin
      s <= '0;
    end else begin
      unique case (estado)
        REPOSO: begin
          if (pop) begin
            codigo <= cabeza;
            s      <= one_hot(cabeza);
            cuenta <= CARGA;
            estado <= ACTIVO;
          end
        end
        ACTIVO: begin
          if (cuenta != '0) begin
            // Reload also restores s after an enable pause.
            cuenta <= cuenta - CW'(1);
            s      <= one_hot(codigo);
          end else if (pop) begin
            codigo <= cabeza;
            s      <= one_hot(cabeza);
            cuenta <= CARGA;
          end else begin
            s      <= '0;
            estado <= REPOSO;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule
